// File: rtl/alg_amba_vip_channel_sink_if.sv
// Valid/id/data/ready beat channel between the shaper (master) and the sink (slave).
interface alg_amba_vip_channel_sink_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 5
) ();

   logic                  s_valid;
   logic [ID_WIDTH-1:0]   s_id;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;

   modport master (output s_valid, output s_id, output s_data, input s_ready);
   modport slave  (input s_valid, input s_id, input s_data, output s_ready);

endinterface

// File: rtl/alg_amba_vip_channel_sink.sv
// Receive-side endpoint of a shaped VIP channel: LFSR-driven backpressure,
// per-ID in-order sequence checking, protocol stability checking, an
// inactivity timeout and saturating statistics with sticky error capture.
// The sequence table is built from flops, so a table write on one beat is
// already visible to a same-ID beat in the very next cycle without a bubble.
module alg_amba_vip_channel_sink #(
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 5,
   parameter int ID_START   = 0,
   parameter int ID_END     = 31,
   parameter int TIMEOUT_W  = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 clear,
   input  logic [15:0]          seed,
   input  logic                 seed_rst,
   input  logic [7:0]           stall_proba,
   input  logic [31:0]          expected_beats,
   input  logic [TIMEOUT_W-1:0] timeout,
   alg_amba_vip_channel_sink_if.slave s,
   output logic [31:0]          stats_nbbeat,
   output logic [31:0]          stats_nberror,
   output logic                 err_flag,
   output logic [ID_WIDTH-1:0]  err_first_id,
   output logic [15:0]          err_first_seq,
   output logic                 proto_err,
   output logic                 timeout_err,
   output logic                 done
);

   localparam int          NUM_IDS   = 1 << ID_WIDTH;
   localparam logic [15:0] LFSR_INIT = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   logic [15:0]           lfsr;
   logic [15:0]           exp_seq [NUM_IDS];
   logic [TIMEOUT_W-1:0]  timer;
   logic [TIMEOUT_W-1:0]  timer_next;
   logic                  stall_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  hs;
   logic                  id_illegal;
   logic                  hdr_mismatch;
   logic                  seq_mismatch;
   logic                  beat_err;

   assign s.s_ready    = ~(lfsr[7:0] < stall_proba);
   assign hs           = s.s_valid & s.s_ready;
   assign done         = (stats_nbbeat == expected_beats);

   assign id_illegal   = (int'(s.s_id) < ID_START) || (int'(s.s_id) > ID_END);
   assign hdr_mismatch = (s.s_data[23:16] != 8'(s.s_id));
   assign seq_mismatch = (s.s_data[15:0] != exp_seq[s.s_id]);
   assign beat_err     = id_illegal | hdr_mismatch | seq_mismatch;

   // Galois LFSR for backpressure; a zero seed would lock up, so it falls back to the default
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr <= LFSR_INIT;
      end else if (seed_rst) begin
         lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   // Beat accounting: statistics, sequence table resync and first-error capture; clear beats any handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stats_nbbeat  <= '0;
         stats_nberror <= '0;
         err_flag      <= 1'b0;
         err_first_id  <= '0;
         err_first_seq <= '0;
         for (int k = 0; k < NUM_IDS; k++) exp_seq[k] <= '0;
      end else if (clear) begin
         stats_nbbeat  <= '0;
         stats_nberror <= '0;
         err_flag      <= 1'b0;
         err_first_id  <= '0;
         err_first_seq <= '0;
         for (int k = 0; k < NUM_IDS; k++) exp_seq[k] <= '0;
      end else if (hs) begin
         if (stats_nbbeat != '1) stats_nbbeat <= stats_nbbeat + 32'd1;
         if (beat_err) begin
            if (stats_nberror != '1) stats_nberror <= stats_nberror + 32'd1;
            if (!err_flag) begin
               err_flag      <= 1'b1;
               err_first_id  <= s.s_id;
               err_first_seq <= s.s_data[15:0];
            end
         end
         if (!id_illegal) exp_seq[s.s_id] <= s.s_data[15:0] + 16'd1;
      end
   end

   // A stalled beat must stay valid with identical id and payload on the following cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_q   <= 1'b0;
         id_q      <= '0;
         data_q    <= '0;
         proto_err <= 1'b0;
      end else begin
         stall_q <= s.s_valid & ~s.s_ready;
         id_q    <= s.s_id;
         data_q  <= s.s_data;
         if (clear) begin
            proto_err <= 1'b0;
         end else if (stall_q && (!s.s_valid || (s.s_id != id_q) || (s.s_data != data_q))) begin
            proto_err <= 1'b1;
         end
      end
   end

   // Next inactivity count: restarts on traffic, clear or completion, otherwise saturates upward
   always_comb begin
      timer_next = timer;
      if (hs || clear || done) begin
         timer_next = '0;
      end else if (timer != '1) begin
         timer_next = timer + 1'b1;
      end
   end

   // Inactivity timer; the flag rises on the same edge the count reaches the limit
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer       <= '0;
         timeout_err <= 1'b0;
      end else begin
         timer <= timer_next;
         if (clear) begin
            timeout_err <= 1'b0;
         end else if ((timeout != '0) && (timer_next == timeout)) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alg_amba_vip_channel_sink.sv
// Scoreboard bench for alg_amba_vip_channel_sink. Two instances share the
// stimulus: dut_a uses the full ID range, dut_b limits legal IDs to 0..15.
module tb_alg_amba_vip_channel_sink;

   localparam int DW = 128;
   localparam int IW = 5;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          clear = 1'b0;
   logic          seed_rst = 1'b0;
   logic [15:0]   seed = 16'h0;
   logic [7:0]    stall_proba = 8'h80;
   logic [31:0]   expected_beats = 32'd100;
   logic [TW-1:0] timeout = '0;

   logic          drv_valid = 1'b0;
   logic [IW-1:0] drv_id = '0;
   logic [DW-1:0] drv_data = '0;

   logic [31:0] a_nbbeat, a_nberror, b_nbbeat, b_nberror;
   logic        a_err_flag, a_proto_err, a_timeout_err, a_done;
   logic        b_err_flag, b_proto_err, b_timeout_err, b_done;
   logic [IW-1:0] a_first_id, b_first_id;
   logic [15:0]   a_first_seq, b_first_seq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] nbbeat;
      logic [31:0] nberror;
   } exp_t;
   exp_t sb_q[$];

   logic [31:0] exp_beats = '0;
   logic [31:0] exp_errs = '0;
   int stall_cycles = 0;
   int total_cycles = 0;

   alg_amba_vip_channel_sink_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus_a ();
   alg_amba_vip_channel_sink_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus_b ();

   assign bus_a.s_valid = drv_valid;
   assign bus_a.s_id    = drv_id;
   assign bus_a.s_data  = drv_data;
   assign bus_b.s_valid = drv_valid;
   assign bus_b.s_id    = drv_id;
   assign bus_b.s_data  = drv_data;

   alg_amba_vip_channel_sink #(
      .DATA_WIDTH(DW), .ID_WIDTH(IW), .ID_START(0), .ID_END(31), .TIMEOUT_W(TW)
   ) dut_a (
      .clk(clk), .resetn(resetn), .clear(clear), .seed(seed), .seed_rst(seed_rst),
      .stall_proba(stall_proba), .expected_beats(expected_beats), .timeout(timeout),
      .s(bus_a.slave),
      .stats_nbbeat(a_nbbeat), .stats_nberror(a_nberror), .err_flag(a_err_flag),
      .err_first_id(a_first_id), .err_first_seq(a_first_seq), .proto_err(a_proto_err),
      .timeout_err(a_timeout_err), .done(a_done)
   );

   alg_amba_vip_channel_sink #(
      .DATA_WIDTH(DW), .ID_WIDTH(IW), .ID_START(0), .ID_END(15), .TIMEOUT_W(TW)
   ) dut_b (
      .clk(clk), .resetn(resetn), .clear(clear), .seed(seed), .seed_rst(seed_rst),
      .stall_proba(stall_proba), .expected_beats(expected_beats), .timeout(timeout),
      .s(bus_b.slave),
      .stats_nbbeat(b_nbbeat), .stats_nberror(b_nberror), .err_flag(b_err_flag),
      .err_first_id(b_first_id), .err_first_seq(b_first_seq), .proto_err(b_proto_err),
      .timeout_err(b_timeout_err), .done(b_done)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard stop in case something wedges
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
      end
   endtask

   // Drives one beat from a negedge, holds it through any stall, pushes the
   // hand-computed expected statistics and returns at the negedge after acceptance.
   task automatic applyStimulus(input logic [IW-1:0] id, input logic [15:0] seq,
                                input logic [7:0] hdr, input bit is_err, input bit with_clear);
      int budget = 0;
      drv_valid = 1'b1;
      drv_id    = id;
      drv_data  = '0;
      drv_data[15:0]  = seq;
      drv_data[23:16] = hdr;
      drv_data[63:32] = {seq, ~seq};
      clear     = with_clear;
      while (!bus_a.s_ready && budget < 200) begin
         @(negedge clk);
         budget++;
         stall_cycles++;
         total_cycles++;
      end
      if (budget >= 200) begin
         checkOutput("ready_wait_budget", 32'(budget), 32'd0);
         drv_valid = 1'b0;
         clear     = 1'b0;
         return;
      end
      if (with_clear) begin
         exp_beats = '0;
         exp_errs  = '0;
      end else begin
         exp_beats = exp_beats + 32'd1;
         if (is_err) exp_errs = exp_errs + 32'd1;
      end
      sb_q.push_back('{exp_beats, exp_errs});
      total_cycles++;
      @(negedge clk);
      drv_valid = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      exp_beats = '0;
      exp_errs  = '0;
   endtask

   task automatic pulseSeed(input logic [15:0] value);
      seed     = value;
      seed_rst = 1'b1;
      @(negedge clk);
      seed_rst = 1'b0;
   endtask

   // Monitor: every accepted beat on dut_a pops one expectation and compares the registered stats
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (resetn && bus_a.s_valid && bus_a.s_ready) begin
            #1;
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_beat", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("sb_nbbeat", a_nbbeat, e.nbbeat);
               checkOutput("sb_nberror", a_nberror, e.nberror);
            end
         end
      end
   end

   // Directed test sequence
   initial begin
      int ids [3];
      int budget;
      ids = '{0, 7, 31};

      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 32'(bus_a.s_ready), 32'd1);
      checkOutput("rst_nbbeat", a_nbbeat, 32'd0);
      checkOutput("rst_nberror", a_nberror, 32'd0);
      checkOutput("rst_err_flag", 32'(a_err_flag), 32'd0);
      checkOutput("rst_proto_err", 32'(a_proto_err), 32'd0);
      checkOutput("rst_timeout_err", 32'(a_timeout_err), 32'd0);
      checkOutput("rst_first_id", 32'(a_first_id), 32'd0);
      checkOutput("rst_first_seq", 32'(a_first_seq), 32'd0);
      checkOutput("rst_done_nonzero_exp", 32'(a_done), 32'd0);
      expected_beats = 32'd0;
      #1;
      checkOutput("rst_done_zero_exp", 32'(a_done), 32'd1);
      expected_beats = 32'd100;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      $display("[TB] LFSR seeding and stepping");
      stall_proba = 8'h80;
      pulseSeed(16'h1234);
      checkOutput("lfsr_1234", 32'(bus_a.s_ready), 32'd0);
      @(negedge clk);
      checkOutput("lfsr_091A", 32'(bus_a.s_ready), 32'd0);
      @(negedge clk);
      checkOutput("lfsr_048D", 32'(bus_a.s_ready), 32'd1);
      @(negedge clk);
      checkOutput("lfsr_B646", 32'(bus_a.s_ready), 32'd0);
      pulseSeed(16'h0000);
      checkOutput("lfsr_zero_seed", 32'(bus_a.s_ready), 32'd1);

      $display("[TB] in-order stream");
      stall_proba    = 8'h00;
      expected_beats = 32'd100;
      pulseClear();
      stall_cycles = 0;
      for (int q = 0; q < 100; q++) applyStimulus(5'd3, 16'(q), 8'd3, 1'b0, 1'b0);
      checkOutput("inorder_stalls", 32'(stall_cycles), 32'd0);
      checkOutput("inorder_nbbeat", a_nbbeat, 32'd100);
      checkOutput("inorder_nberror", a_nberror, 32'd0);
      checkOutput("inorder_done", 32'(a_done), 32'd1);

      $display("[TB] interleaved IDs");
      expected_beats = 32'd1000;
      pulseClear();
      for (int q = 0; q < 16; q++)
         for (int k = 0; k < 3; k++) applyStimulus(IW'(ids[k]), 16'(q), 8'(ids[k]), 1'b0, 1'b0);
      checkOutput("ilv_nberror", a_nberror, 32'd0);
      checkOutput("ilv_err_flag", 32'(a_err_flag), 32'd0);
      pulseClear();
      for (int q = 0; q < 16; q++)
         for (int k = 0; k < 3; k++)
            if (!(ids[k] == 7 && q == 5))
               applyStimulus(IW'(ids[k]), 16'(q), 8'(ids[k]), (ids[k] == 7 && q == 6), 1'b0);
      checkOutput("drop_nberror", a_nberror, 32'd1);
      checkOutput("drop_err_flag", 32'(a_err_flag), 32'd1);
      checkOutput("drop_first_id", 32'(a_first_id), 32'd7);
      checkOutput("drop_first_seq", 32'(a_first_seq), 32'd6);

      $display("[TB] illegal ID");
      pulseClear();
      applyStimulus(5'd20, 16'd0, 8'd20, 1'b0, 1'b0);
      applyStimulus(5'd20, 16'd1, 8'd20, 1'b0, 1'b0);
      checkOutput("illegal_nberror", b_nberror, 32'd2);
      checkOutput("illegal_first_id", 32'(b_first_id), 32'd20);
      checkOutput("illegal_first_seq", 32'(b_first_seq), 32'd0);

      $display("[TB] clear with handshake");
      pulseClear();
      applyStimulus(5'd9, 16'd0, 8'd9, 1'b0, 1'b0);
      applyStimulus(5'd9, 16'd1, 8'd9, 1'b0, 1'b0);
      applyStimulus(5'd9, 16'd2, 8'd9, 1'b0, 1'b1);
      checkOutput("clrhs_nbbeat", a_nbbeat, 32'd0);
      applyStimulus(5'd9, 16'd0, 8'd9, 1'b0, 1'b0);
      checkOutput("clrhs_nberror", a_nberror, 32'd0);

      $display("[TB] backpressure");
      pulseClear();
      stall_proba = 8'h80;
      pulseSeed(16'h1234);
      stall_cycles = 0;
      total_cycles = 0;
      for (int q = 0; q < 1000; q++) applyStimulus(5'd5, 16'(q), 8'd5, 1'b0, 1'b0);
      checkOutput("bp_nbbeat", a_nbbeat, 32'd1000);
      checkOutput("bp_nberror", a_nberror, 32'd0);
      checkOutput("bp_proto_err", 32'(a_proto_err), 32'd0);
      checkOutput("bp_stall_ratio", 32'((stall_cycles * 100 > total_cycles * 30) &&
                                        (stall_cycles * 100 < total_cycles * 70)), 32'd1);

      stall_proba = 8'hFF;
      budget = 0;
      while (bus_a.s_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("proto_find_stall", 32'(bus_a.s_ready), 32'd0);
      drv_valid = 1'b1;
      drv_id    = 5'd5;
      drv_data  = '0;
      drv_data[15:0]  = 16'd1000;
      drv_data[23:16] = 8'd5;
      @(negedge clk);
      drv_valid = 1'b0;
      @(negedge clk);
      checkOutput("proto_valid_drop", 32'(a_proto_err), 32'd1);
      pulseClear();
      checkOutput("proto_cleared", 32'(a_proto_err), 32'd0);

      $display("[TB] timeout");
      stall_proba    = 8'h00;
      expected_beats = 32'd10;
      timeout        = 16'd50;
      pulseClear();
      for (int q = 0; q < 4; q++) applyStimulus(5'd1, 16'(q), 8'd1, 1'b0, 1'b0);
      repeat (49) @(negedge clk);
      checkOutput("timeout_before", 32'(a_timeout_err), 32'd0);
      @(negedge clk);
      checkOutput("timeout_at_50", 32'(a_timeout_err), 32'd1);
      timeout = '0;
      pulseClear();
      applyStimulus(5'd1, 16'd0, 8'd1, 1'b0, 1'b0);
      repeat (100) @(negedge clk);
      checkOutput("timeout_disabled", 32'(a_timeout_err), 32'd0);

      $display("[TB] async reset mid-stream");
      expected_beats = 32'd1000;
      pulseClear();
      for (int q = 0; q < 5; q++) applyStimulus(5'd2, 16'(q), 8'd2, 1'b0, 1'b0);
      applyStimulus(5'd2, 16'd9, 8'd2, 1'b1, 1'b0);
      applyStimulus(5'd2, 16'd10, 8'd2, 1'b0, 1'b0);
      checkOutput("pre_rst_err_flag", 32'(a_err_flag), 32'd1);
      stall_proba = 8'hF0;
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("arst_nbbeat", a_nbbeat, 32'd0);
      checkOutput("arst_nberror", a_nberror, 32'd0);
      checkOutput("arst_err_flag", 32'(a_err_flag), 32'd0);
      checkOutput("arst_first_id", 32'(a_first_id), 32'd0);
      checkOutput("arst_first_seq", 32'(a_first_seq), 32'd0);
      checkOutput("arst_ready_lfsr", 32'(bus_a.s_ready), 32'd0);
      checkOutput("arst_done", 32'(a_done), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
